bist_misr_analyzer: RTL and testbench

Response-side stage of the BIST datapath. It consumes the DUT response words produced while the pseudo-random pattern generator drives the DUT, and compacts them into a Multiple-Input Signature Register (MISR) over a programmed number of patterns. At the end of the run it compares the signature against a golden value and reports pass/fail to the BIST controller.

---
 rtl/bist_misr_analyzer_pkg.sv | 25 ++
 rtl/bist_misr_analyzer_misr_core.sv | 41 ++++
 rtl/bist_misr_analyzer.sv | 110 +++++++++++
 tb/tb_bist_misr_analyzer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bist_misr_analyzer_pkg.sv
// Shared BIST definitions: FSM state encoding and MISR/LFSR tap masks.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMPARE = 2'd2
  } state_t;

  // Tap masks: a set bit marks a bit that feeds the XOR feedback.
  localparam logic [7:0]  TAPS_8  = 8'hB8;          // bits 7,5,4,3
  localparam logic [15:0] TAPS_16 = 16'hD008;       // bits 15,14,12,3
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // bits 31,21,1,0

  // Tap mask for a supported width, zero-extended to 32 bits.
  function automatic logic [31:0] tap_mask(input int width);
    case (width)
      8:       return {24'd0, TAPS_8};
      16:      return {16'd0, TAPS_16};
      32:      return TAPS_32;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/bist_misr_analyzer_misr_core.sv
// Multiple-input signature register: the single home of the MISR polynomial.
module misr_core
  import bist_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] MISR_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sig
);

  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : g_bad_width
    $error("misr_core: WIDTH must be 8, 16 or 32");
  end

  localparam logic [31:0]      TAPS_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic fb;

  // Feedback is the parity of the tapped signature bits.
  always_comb begin
    fb = ^(sig & TAPS);
  end

  // Load restarts from the seed; enable shifts in feedback and folds in data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= MISR_SEED;
    end else if (load) begin
      sig <= MISR_SEED;
    end else if (enable) begin
      sig <= {sig[WIDTH-2:0], fb} ^ data_in;
    end
  end

endmodule

// File: rtl/bist_misr_analyzer.sv
// Response analyzer: compacts a programmed number of response beats into a
// MISR signature and reports a pass/fail verdict against a golden value.
//
// Handshake: a beat transfers on a rising edge where resp_valid && resp_ready.
// resp_ready is high only in RUN and is withdrawn while abort is asserted, so
// an aborting cycle never transfers a beat and the MISR/count stay frozen.
module bist_misr_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] MISR_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] pattern_count,
  input  logic [WIDTH-1:0] golden_sig,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] beat_count
);

  state_t           state;
  logic [CNT_W-1:0] target_q;
  logic [WIDTH-1:0] golden_q;
  logic             load;
  logic             accept;
  logic             last_beat;

  // Control decode: run launch, beat transfer and end-of-run detection.
  always_comb begin
    resp_ready = (state == RUN) && !abort;
    busy       = (state == RUN) || (state == COMPARE);
    load       = (state == IDLE) && start && !abort;
    accept     = resp_valid && resp_ready;
    last_beat  = accept && ((beat_count + CNT_W'(1)) == target_q);
  end

  misr_core #(
    .WIDTH     (WIDTH),
    .MISR_SEED (MISR_SEED)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .enable  (accept),
    .data_in (resp_data),
    .sig     (signature)
  );

  // FSM, beat counter, run configuration latch and verdict registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat_count <= '0;
      target_q   <= '0;
      golden_q   <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            beat_count <= '0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            target_q   <= pattern_count;
            golden_q   <= golden_sig;
            state      <= (pattern_count == '0) ? COMPARE : RUN;
          end
        end
        RUN: begin
          if (abort) begin
            pass  <= 1'b0;
            fail  <= 1'b0;
            state <= IDLE;
          end else if (accept) begin
            beat_count <= beat_count + CNT_W'(1);
            if (last_beat) begin
              state <= COMPARE;
            end
          end
        end
        COMPARE: begin
          if (abort) begin
            pass <= 1'b0;
            fail <= 1'b0;
          end else begin
            pass <= (signature == golden_q);
            fail <= (signature != golden_q);
            done <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Bench for bist_misr_analyzer: two instances (seed 0 and seed 0x8000) share
// the stimulus; a behavioural MISR model predicts signatures and verdicts.
module tb_bist_misr_analyzer;

  localparam int W  = 16;
  localparam int CW = 16;
  localparam logic [W-1:0] SEED_A = 16'h0000;
  localparam logic [W-1:0] SEED_B = 16'h8000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, abort, resp_valid;
  logic [CW-1:0] pattern_count;
  logic [W-1:0]  golden_a, golden_b, resp_data;

  logic          ready_a, busy_a, done_a, pass_a, fail_a;
  logic [W-1:0]  sig_a;
  logic [CW-1:0] cnt_a;
  logic          ready_b, busy_b, done_b, pass_b, fail_b;
  logic [W-1:0]  sig_b;
  logic [CW-1:0] cnt_b;

  bist_misr_analyzer #(.WIDTH(W), .CNT_W(CW), .MISR_SEED(SEED_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern_count(pattern_count), .golden_sig(golden_a),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(ready_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
    .signature(sig_a), .beat_count(cnt_a)
  );

  bist_misr_analyzer #(.WIDTH(W), .CNT_W(CW), .MISR_SEED(SEED_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern_count(pattern_count), .golden_sig(golden_b),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(ready_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
    .signature(sig_b), .beat_count(cnt_b)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] beat_q[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signature after compacting the first k beats of beat_q from a seed:
  // shift left, feedback = parity of bits 15,14,12,3, then XOR the word.
  function automatic logic [W-1:0] model_sig(input logic [W-1:0] seed, input int k);
    logic [W-1:0] s;
    logic         f;
    s = seed;
    for (int i = 0; i < k; i++) begin
      f = s[15] ^ s[14] ^ s[12] ^ s[3];
      s = ((s << 1) | W'(f)) ^ beat_q[i];
    end
    return s;
  endfunction

  function automatic logic [W-1:0] corrupt(input logic [W-1:0] v);
    logic [W-1:0] one;
    one = 16'h0001;
    return v ^ (one << $urandom_range(0, 15));
  endfunction

  // ---------------- driver tasks ----------------
  // One run of n beats from beat_q; aborts (with a simultaneous start) once
  // abort_at beats have been accepted, if abort_at < n.
  task automatic run_case(input int n, input int abort_at, input bit good_a, input bit good_b);
    int acc;
    logic [W-1:0] fa, fb, ga, gb;
    fa = model_sig(SEED_A, n);
    fb = model_sig(SEED_B, n);
    ga = good_a ? fa : corrupt(fa);
    gb = good_b ? fb : corrupt(fb);

    @(negedge clk);
    start = 1'b1; abort = 1'b0; resp_valid = 1'b0;
    pattern_count = CW'(n); golden_a = ga; golden_b = gb;
    @(negedge clk);
    start = 1'b0;
    pattern_count = CW'($urandom);  // must have been latched already
    golden_a = W'($urandom); golden_b = W'($urandom);
    check("load_busy", busy_a, 1);
    check("load_sig_a", sig_a, SEED_A);
    check("load_sig_b", sig_b, SEED_B);
    check("load_cnt", cnt_a, 0);
    check("load_verdict", {done_a, pass_a, fail_a}, 0);
    check("load_ready", ready_a, (n > 0) ? 1 : 0);

    acc = 0;
    for (int cyc = 0; cyc < 4 * n + 20 && acc < n; cyc++) begin
      if (acc == abort_at) begin
        abort = 1'b1; start = 1'b1; resp_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_verdict", {done_a, pass_a, fail_a, done_b, pass_b, fail_b}, 0);
        check("abort_cnt", cnt_a, acc);
        check("abort_sig_a", sig_a, model_sig(SEED_A, acc));
        check("abort_sig_b", sig_b, model_sig(SEED_B, acc));
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("abort_idle", {busy_a, done_a, pass_a, fail_a}, 0);
        end
        return;
      end
      check("run_ready", ready_a, 1);
      resp_valid = ($urandom_range(0, 3) != 0);
      resp_data  = resp_valid ? beat_q[acc] : W'($urandom);
      start      = ($urandom_range(0, 5) == 0);  // ignored while busy
      pattern_count = CW'($urandom_range(0, 3));
      if (resp_valid) exp_q.push_back(model_sig(SEED_A, acc + 1));
      @(negedge clk);
      start = 1'b0;
      if (resp_valid) begin
        acc++;
        check("beat_sig_a", sig_a, exp_q.pop_front());
        check("beat_cnt", cnt_a, acc);
      end else begin
        check("gap_sig_a", sig_a, model_sig(SEED_A, acc));
      end
      resp_valid = 1'b0;
    end
    check("beat_budget", acc, n);

    // COMPARE cycle: no verdict yet; stray beats must be ignored.
    check("cmp_busy", busy_a, 1);
    check("cmp_ready", ready_a, 0);
    check("cmp_done", done_a, 0);
    check("cmp_sig_a", sig_a, fa);
    check("cmp_sig_b", sig_b, fb);
    resp_valid = 1'b1; resp_data = W'($urandom);
    @(negedge clk);
    check("done_a", done_a, 1);
    check("done_b", done_b, 1);
    check("pass_a", pass_a, good_a);
    check("fail_a", fail_a, !good_a);
    check("pass_b", pass_b, good_b);
    check("fail_b", fail_b, !good_b);
    check("idle_busy", busy_a, 0);
    @(negedge clk);
    resp_valid = 1'b0;
    check("done_low", {done_a, done_b}, 0);
    check("held_pass_a", pass_a, good_a);
    check("held_sig_a", sig_a, fa);
    check("held_sig_b", sig_b, fb);
    check("held_cnt", cnt_a, n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] saved;
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
    pattern_count = '0; golden_a = '0; golden_b = '0; resp_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_sig_a", sig_a, SEED_A);
    check("rst_sig_b", sig_b, SEED_B);
    check("rst_flags", {busy_a, done_a, pass_a, fail_a, ready_a}, 0);
    check("rst_cnt", cnt_a, 0);
    rst = 1'b0;

    // Known-answer runs.
    beat_q = '{16'h0001, 16'h0000, 16'h0000};
    run_case(3, 99, 1, 1);
    check("kat_sig_a", sig_a, 16'h0004);
    check("kat_pass_a", pass_a, 1);
    run_case(3, 99, 0, 1);
    check("kat_fail_a", fail_a, 1);
    beat_q = '{16'h0000};
    run_case(1, 99, 1, 1);
    check("kat_sig_b", sig_b, 16'h0001);

    // Zero-length run goes straight to compare against the seed.
    run_case(0, 99, 1, 1);

    // Abort after two beats with a coincident start.
    beat_q = {};
    for (int i = 0; i < 4; i++) beat_q.push_back(W'($urandom));
    run_case(4, 2, 1, 1);

    // Randomized runs.
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(0, 12);
      beat_q = {};
      for (int i = 0; i < n; i++) beat_q.push_back(W'($urandom));
      run_case(n, ($urandom_range(0, 4) == 0) ? $urandom_range(0, n) : 99,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // start together with abort in IDLE does nothing.
    saved = sig_a;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; pattern_count = 16'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", busy_a, 0);
    check("idle_abort_sig", sig_a, saved);

    // Asynchronous reset in the middle of a run.
    beat_q = {};
    for (int i = 0; i < 5; i++) beat_q.push_back(W'($urandom));
    @(negedge clk);
    start = 1'b1; pattern_count = 16'd5; golden_a = '0; golden_b = '0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_valid = 1'b1; resp_data = beat_q[i];
      @(negedge clk);
    end
    check("pre_rst_cnt", cnt_a, 2);
    check("pre_rst_sig", sig_a, model_sig(SEED_A, 2));
    #2 rst = 1'b1;
    #1;
    check("arst_sig_a", sig_a, SEED_A);
    check("arst_sig_b", sig_b, SEED_B);
    check("arst_cnt", cnt_a, 0);
    check("arst_flags", {busy_a, ready_a, done_a, pass_a, fail_a}, 0);
    @(negedge clk);
    rst = 1'b0; resp_valid = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
